fir_filter_pipe: RTL and testbench
==================================

// Module: fir_filter_pipe
// PURPOSE
//   Parametrised, pipelined direct-form FIR filter. Successor to fir_filter.
//   Adds: generic tap count and widths, valid handshake with bubbles, run-time
//   coefficient writes, output scaling with rounding, and optional saturation.
//   Sits between the sample source and downstream DSP; one sample per clock max.
// PARAMETERS
//   DATA_W     16  signed input sample width
//   COEF_W     16  signed coefficient width
//   TAPS        8  number of taps (>=2, need not be a power of 2)
//   OUT_W      32  signed output width
//   OUT_SHIFT   0  arithmetic right shift applied to accumulator before output
//   ACC_W      localparam = DATA_W+COEF_W+$clog2(TAPS); full-precision sum
// PORTS
//   clk         in   1                 rising-edge clock
//   reset_n     in   1                 asynchronous, active-low reset
//   in_valid    in   1                 x_in valid this cycle
//   x_in        in   DATA_W            signed sample
//   coef_we     in   1                 coefficient write strobe
//   coef_addr   in   $clog2(TAPS)      tap index of write
//   coef_wdata  in   COEF_W            signed coefficient value
//   out_valid   out  1                 y_out valid this cycle (1-cycle pulse per sample)
//   y_out       out  OUT_W             signed filtered sample
//   sat_flag    out  1                 y_out was clipped (valid with out_valid)
// BEHAVIOUR
//   - Reset (reset_n low, async): delay line, product regs, sum reg, y_out,
//     out_valid, sat_flag all 0; coef[0]=1, coef[1..TAPS-1]=0 (identity filter).
//   - Stage 0: on edge with in_valid=1, delay line shifts; d[0]<=x_in, d[i]<=d[i-1].
//     in_valid=0: delay line holds (no zero insertion).
//   - Stage 1: p[i] <= d[i]*coef[i] (full DATA_W+COEF_W signed), registered.
//   - Stage 2: acc <= sum of p[i] in ACC_W, registered; then scaled to y_out.
//   - Latency: sample accepted at edge k -> out_valid=1, y_out valid after edge
//     k+2. Valid travels a 2-deep shift pipe; bubbles in in_valid appear as
//     bubbles in out_valid, one output per accepted input, order preserved.
//   - y[n] = sum_{i=0..TAPS-1} coef[i]*x[n-i]; pre-history samples count as 0.
//   - Scaling: OUT_SHIFT>0 -> add 2^(OUT_SHIFT-1) then arithmetic shift right
//     (round half up); OUT_SHIFT=0 -> no rounding.
//   - Coef write: coef[coef_addr] updated at the edge with coef_we=1; stage 1 at
//     that same edge still uses the old value, later edges use the new one.
//     Write with coef_addr>=TAPS ignored. Writes allowed concurrently with data.
//   - y_out/sat_flag hold last value when out_valid=0.
//   - Reset mid-stream: in-flight samples discarded, out_valid drops immediately,
//     coefficients return to identity; first post-reset output at edge k+2.
// CONFIGURATION
//   FIR_SAT_EN defined: scaled result outside signed OUT_W range clamps to
//     +2^(OUT_W-1)-1 / -2^(OUT_W-1); sat_flag=1 with that out_valid, else 0.
//   FIR_SAT_EN undefined: result sign-extended or truncated to OUT_W LSBs
//     (two's-complement wrap); sat_flag tied 0.
// STRUCTURE
//   - Package fir_pkg: ACC_W/addr-width helper functions, rounding/saturation
//     function, coefficient reset constants.
//   - Sub-module fir_tap: one tap (delay reg + coef reg + product reg),
//     instantiated TAPS times by generate; adder tree and output stage stay here.
// TESTING (TAPS=8, DATA_W=COEF_W=16, OUT_W=32, OUT_SHIFT=0 unless stated)
//   - Reset coefs, in_valid=1, x=1..8 -> y=1..8, each out_valid 2 clks after input.
//   - Write all coef=1, x=1..8 then 0s -> y=1,3,6,10,15,21,28,36,35,33,30,26,21,15,8,0.
//   - Coefs 1..8, impulse x=1 then 0s -> y=1,2,3,4,5,6,7,8,0; in_valid toggled
//     every other cycle -> same y sequence, out_valid pulses track the gaps.
//   - OUT_W=16, all coef=0x7FFF, x=0x7FFF held 8 samples -> with FIR_SAT_EN
//     y=32767, sat_flag=1; without -> low 16 bits of 8*0x3FFF0001, sat_flag=0.
//   - OUT_SHIFT=2, coef[0]=1, x=6 -> y=2 (6+2>>2); x=-6 -> y=-1.
//   - Drop reset_n mid-stream with 2 samples in flight -> out_valid=0 at once,
//     no stale outputs after release, filter back to identity (x=5 -> y=5).

Source files
------------

// File: rtl/fir_filter_pipe_pkg.sv
// fir_pkg: width helpers, reset coefficients, rounding and clamping.
// Scaling math is done in a 64-bit signed domain (ACC_W must not exceed 64).
package fir_pkg;

  localparam int CALC_W = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic int acc_w(
    input int dw,
    input int cw,
    input int taps
  );
    return dw + cw + $clog2(taps);
  endfunction

  function automatic int addr_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  // Identity filter after reset: only tap 0 passes the input.
  function automatic int coef_rst(input int idx);
    return (idx == 0) ? 1 : 0;
  endfunction

  function automatic calc_t round_shift(
    input calc_t v,
    input int    sh
  );
    calc_t bias;
    bias = '0;
    if (sh > 0)
      bias = calc_t'(1) <<< (sh - 1);
    return (v + bias) >>> sh;
  endfunction

  function automatic calc_t sat_clip(
    input  calc_t v,
    input  int    ow,
    output logic  clip
  );
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (ow - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    clip = 1'b1;
    if (v > hi)
      return hi;
    if (v < lo)
      return lo;
    clip = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/fir_filter_pipe_if.sv
// fir_filter_pipe_if: sample, coefficient-write and result signals.
// master = sample source / host, slave = the filter.
interface fir_filter_pipe_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 32
);

  localparam int AW = fir_pkg::addr_w(TAPS);

  logic                     in_valid;
  logic signed [DATA_W-1:0] x_in;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  y_out;
  logic                     sat_flag;

  modport master (
    output in_valid, x_in,
    output coef_we, coef_addr, coef_wdata,
    input  out_valid, y_out, sat_flag
  );

  modport slave (
    input  in_valid, x_in,
    input  coef_we, coef_addr, coef_wdata,
    output out_valid, y_out, sat_flag
  );

endinterface

// File: rtl/fir_filter_pipe_tap.sv
// fir_tap: one FIR tap -- delay register, coefficient register and
// registered full-precision product.
module fir_tap
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int IDX    = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_shift,
  input  logic signed [DATA_W-1:0]        i_d,
  input  logic                            i_cwe,
  input  logic signed [COEF_W-1:0]        i_cdata,
  output logic signed [DATA_W-1:0]        o_d,
  output logic signed [DATA_W+COEF_W-1:0] o_p
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] C_RST =
    COEF_W'(coef_rst(IDX));

  logic signed [DATA_W-1:0] r_d;
  logic signed [COEF_W-1:0] r_coef;
  logic signed [PROD_W-1:0] r_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d    <= '0;
      r_coef <= C_RST;
      r_p    <= '0;
    end else begin
      if (i_shift)
        r_d <= i_d;
      if (i_cwe)
        r_coef <= i_cdata;
      r_p <= PROD_W'(r_d) * PROD_W'(r_coef);
    end
  end

  assign o_d = r_d;
  assign o_p = r_p;

endmodule

// File: rtl/fir_filter_pipe.sv
// fir_filter_pipe: pipelined direct-form FIR, 2-cycle latency, bubbles kept.
// Define FIR_SAT_EN to clamp out-of-range results and raise sat_flag.
module fir_filter_pipe
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 8,
  parameter int OUT_W     = 32,
  parameter int OUT_SHIFT = 0
) (
  input logic              clk,
  input logic              reset_n,
  fir_filter_pipe_if.slave bus
);

  localparam int AW     = addr_w(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] w_d [TAPS];
  logic signed [PROD_W-1:0] w_p [TAPS];
  logic signed [ACC_W-1:0]  w_sum;
  calc_t                    w_rnd;
  calc_t                    w_y;
  logic                     w_clip;

  logic [1:0]              r_vld;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_y;
  logic                    r_sat;

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    logic signed [DATA_W-1:0] w_din;
    if (i == 0) begin : g_head
      assign w_din = bus.x_in;
    end else begin : g_link
      assign w_din = w_d[i-1];
    end

    fir_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .IDX    (i)
    ) u_tap (
      .clk     (clk),
      .reset_n (reset_n),
      .i_shift (bus.in_valid),
      .i_d     (w_din),
      .i_cwe   (bus.coef_we &&
                (bus.coef_addr == AW'(i))),
      .i_cdata (bus.coef_wdata),
      .o_d     (w_d[i]),
      .o_p     (w_p[i])
    );
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < TAPS; i++)
      w_sum = w_sum + ACC_W'(w_p[i]);
  end

  always_comb begin
    w_rnd = round_shift(calc_t'(w_sum), OUT_SHIFT);
`ifdef FIR_SAT_EN
    w_y = sat_clip(w_rnd, OUT_W, w_clip);
`else
    w_y    = w_rnd;
    w_clip = 1'b0;
`endif
  end

  // r_vld[1] marks that the products now in the taps belong to a real sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_vld       <= {r_vld[0], bus.in_valid};
      r_out_valid <= r_vld[1];
      if (r_vld[1]) begin
        r_y   <= OUT_W'(w_y);
        r_sat <= w_clip;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.y_out     = r_y;
  assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Scoreboard bench: two filter instances (32-bit/no shift, 16-bit/shift 2)
// driven identically and checked against a tap-history reference model.
module tb_fir_filter_pipe;

  localparam int TAPS = 8;

  typedef struct {
    longint y;
    bit     f;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_filter_pipe_if #(.OUT_W(32)) ifa ();
  fir_filter_pipe_if #(.OUT_W(16)) ifb ();

  fir_filter_pipe #(.OUT_W(32), .OUT_SHIFT(0)) dut_a (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (ifa)
  );

  fir_filter_pipe #(.OUT_W(16), .OUT_SHIFT(2)) dut_b (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (ifb)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  int     coef[TAPS];
  longint hist[TAPS];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Exact real-number result, then rounding, then clamp or two's-complement wrap.
  function automatic exp_t model_out(input longint s, input int sh,
                                     input int ow);
    exp_t   e;
    longint r, lim, m;
    r = s;
    if (sh > 0)
      r = (s + (longint'(1) <<< (sh - 1))) >>> sh;
    lim = longint'(1) <<< (ow - 1);
    e.f = 1'b0;
`ifdef FIR_SAT_EN
    if (r >= lim) begin
      r = lim - 1;
      e.f = 1'b1;
    end else if (r < -lim) begin
      r = -lim;
      e.f = 1'b1;
    end
`else
    m = 2 * lim;
    r = r % m;
    if (r < 0)
      r += m;
    if (r >= lim)
      r -= m;
`endif
    e.y = r;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      coef[i] = (i == 0) ? 1 : 0;
      hist[i] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic step(input bit v, input int x, input bit we = 0,
                      input int a = 0, input int wd = 0);
    logic signed [15:0] xs, ws;
    longint s;
    xs = 16'(x);
    ws = 16'(wd);
    ifa.in_valid = v;  ifb.in_valid = v;
    ifa.x_in = xs;     ifb.x_in = xs;
    ifa.coef_we = we;  ifb.coef_we = we;
    ifa.coef_addr = 3'(a);
    ifb.coef_addr = 3'(a);
    ifa.coef_wdata = ws;
    ifb.coef_wdata = ws;
    if (we)
      coef[a] = int'(ws);
    if (v) begin
      for (int i = TAPS - 1; i > 0; i--)
        hist[i] = hist[i-1];
      hist[0] = longint'(xs);
      s = 0;
      for (int i = 0; i < TAPS; i++)
        s += longint'(coef[i]) * hist[i];
      qa.push_back(model_out(s, 0, 32));
      qb.push_back(model_out(s, 2, 16));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0);
  endtask

  task automatic set_all(input int c);
    for (int i = 0; i < TAPS; i++)
      step(0, 0, 1, i, c);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ifa.out_valid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_out", 1, 0);
      end else begin
        e = qa.pop_front();
        chk("a_y", longint'(ifa.y_out), e.y);
        chk("a_sat", longint'(ifa.sat_flag), longint'(e.f));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (ifb.out_valid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_out", 1, 0);
      end else begin
        e = qb.pop_front();
        chk("b_y", longint'(ifb.y_out), e.y);
        chk("b_sat", longint'(ifb.sat_flag), longint'(e.f));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int v, x, we, a, wd, p;
    model_reset();
    ifa.in_valid = 0;  ifb.in_valid = 0;
    ifa.x_in = 0;      ifb.x_in = 0;
    ifa.coef_we = 0;   ifb.coef_we = 0;
    ifa.coef_addr = 0; ifb.coef_addr = 0;
    ifa.coef_wdata = 0;
    ifb.coef_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(ifa.out_valid), 0);
    chk("rst_y_out", longint'(ifa.y_out), 0);
    chk("rst_sat", longint'(ifb.sat_flag), 0);
    rst_n = 1'b1;
    idle(2);

    // Latency and hold with reset coefficients.
    step(1, 7);
    chk("lat_edge_k", longint'(ifa.out_valid), 0);
    step(0, 0);
    chk("lat_edge_k1", longint'(ifa.out_valid), 0);
    step(0, 0);
    chk("lat_edge_k2", longint'(ifa.out_valid), 1);
    chk("lat_y", longint'(ifa.y_out), 7);
    idle(3);
    chk("hold_valid", longint'(ifa.out_valid), 0);
    chk("hold_y", longint'(ifa.y_out), 7);

    for (int i = 1; i <= 8; i++)
      step(1, i);
    idle(4);

    set_all(1);
    for (int i = 0; i < 8; i++) step(1, 0);
    for (int i = 1; i <= 8; i++) step(1, i);
    for (int i = 0; i < 8; i++) step(1, 0);
    idle(4);

    for (int i = 0; i < TAPS; i++)
      step(0, 0, 1, i, i + 1);
    step(1, 1);
    for (int i = 0; i < 8; i++) step(1, 0);
    idle(3);
    step(1, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 0);
      step(1, 0);
    end
    idle(4);

    set_all(32'h7FFF);
    for (int i = 0; i < 8; i++) step(1, 32'h7FFF);
    idle(4);

    set_all(0);
    step(0, 0, 1, 0, 1);
    step(1, 6);
    idle(2);
    chk("round_pos", longint'(ifb.y_out), 2);
    step(1, -6);
    idle(2);
    chk("round_neg", longint'(ifb.y_out), -1);
    idle(2);

    // Reset with one output showing and two samples still in flight.
    set_all(3);
    step(1, 3);
    step(1, 4);
    step(1, 5);
    chk("pre_rst_valid", longint'(ifa.out_valid), 1);
    ifa.in_valid = 0;
    ifb.in_valid = 0;
    ifa.coef_we = 0;
    ifb.coef_we = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_a", longint'(ifa.out_valid), 0);
    chk("mid_rst_valid_b", longint'(ifb.out_valid), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    step(1, 5);
    idle(2);
    chk("post_rst_identity", longint'(ifa.y_out), 5);
    idle(2);

    for (int n = 0; n < 1500; n++) begin
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      p  = $urandom_range(0, 9);
      x  = (p == 0) ? 32767 : (p == 1) ? -32768 :
           int'($urandom_range(0, 65535)) - 32768;
      we = ($urandom_range(0, 7) == 0) ? 1 : 0;
      a  = $urandom_range(0, TAPS - 1);
      p  = $urandom_range(0, 5);
      wd = (p == 0) ? 32767 : (p == 1) ? -32768 :
           int'($urandom_range(0, 65535)) - 32768;
      step(v[0], x, we[0], a, wd);
    end
    idle(6);
    chk("drain_a", longint'(qa.size()), 0);
    chk("drain_b", longint'(qb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
